acc_cpu_sequencer: RTL and testbench
====================================

Name: acc_cpu_sequencer

Overview:
Fetch/decode/execute controller for the 16-bit accumulator machine. Owns PC and IR, fetches instructions over a req/ack memory handshake, and resolves control-flow ops (SKIP, JUMP, HALT) locally against AC. It hands all other opcodes to the ALU/accumulator datapath via a start/done handshake. Sits between instruction memory and the existing operation datapath blocks.

Parameters:
ADDR_W, 12, PC / memory address width; PC wraps modulo 2^ADDR_W
DATA_W, 16, instruction and AC width
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-low reset (sampled on rising clk; 0 = reset)
run  input  1  level; start/resume execution from IDLE or HALTED
mem_req  output  1  instruction read request
mem_addr  output  ADDR_W  read address (= PC while mem_req high)
mem_ack  input  1  read data valid this cycle
mem_rdata  input  DATA_W  instruction word
ac  input  DATA_W  accumulator value from datapath (two's complement)
exec_start  output  1  one-cycle pulse: datapath executes exec_op
exec_op  output  4  opcode IR[15:12]
exec_operand  output  ADDR_W  IR[11:0]
exec_done  input  1  datapath completion
pc  output  ADDR_W  current PC
halted  output  1  high in HALTED
retire  output  1  one-cycle pulse per completed instruction

Behaviour:
- Instruction: opcode IR[15:12], operand IR[11:0]. HALT = 4'h0, SKIP = 4'h8, JUMP = 4'h9; all others go to datapath.
- SKIP condition IR[11:10]: 00 skip if ac < 0 (signed); 01 skip if ac == 0; 10 skip if ac > 0 (signed); 11 never skip.
- States: IDLE, FETCH, DECODE, EXEC, WAIT_EXEC, HALTED.
- Reset (rst=0 at a clock edge):
  - state IDLE, PC=RESET_PC, IR=0.
  - Outputs mem_req=0, exec_start=0, retire=0, halted=0.
  - Reset overrides any state, including mid-fetch or mid-exec; an outstanding mem_ack/exec_done is ignored.
- IDLE: stay until run=1, then go to FETCH.
- FETCH:
  - mem_req=1, mem_addr=PC, held until mem_ack.
  - On the mem_ack cycle: IR<=mem_rdata, PC<=PC+1 (wraps), go to DECODE.
  - mem_ack in the same cycle mem_req first rises is accepted. mem_ack while not in FETCH is ignored.
- DECODE (exactly 1 cycle):
  - HALT: go to HALTED, retire=1.
  - JUMP: PC<=operand, retire=1, go to FETCH.
  - SKIP: if condition true, PC<=PC+1 (wraps); retire=1, go to FETCH.
  - Other: go to EXEC.
- EXEC (1 cycle): exec_start=1, with exec_op/exec_operand driven from IR. Go to WAIT_EXEC.
- WAIT_EXEC:
  - Wait for exec_done. exec_done is sampled only from the cycle after exec_start; an exec_done coincident with exec_start is ignored.
  - On exec_done: retire=1, go to FETCH.
- HALTED: halted=1, PC holds the address after HALT. run=1 goes to FETCH and resumes from PC.
- exec_op/exec_operand reflect IR continuously; they are valid whenever exec_start=1.
- Minimum latency:
  - Control-flow instruction: 2 cycles (FETCH with immediate ack + DECODE).
  - Datapath instruction: 4 cycles (FETCH + DECODE + EXEC + WAIT_EXEC with exec_done on first sample).
- ac is sampled in DECODE only.

Optional Feature:
- Macro: ACC_SEQ_SINGLE_STEP_EN.
- Defined:
  - Adds input port `step`.
  - After every retire the FSM enters extra state PAUSE instead of FETCH. HALT still goes to HALTED.
  - In PAUSE, a step=1 cycle goes to FETCH; run is ignored.
  - Reset clears PAUSE to IDLE.
- Undefined: no step port and no PAUSE state; retire goes directly to FETCH.

Test Plan:
1. Reset with rst=0 for 2 cycles, then rst=1, run=1, memory ack is immediate, mem[0]=16'h0000 -> mem_addr=0 on first FETCH; halted=1 two cycles after FETCH; pc=1; retire pulses once.
2. mem[0]=16'h8400 (SKIP if ac==0) with ac=0, mem[2]=HALT -> FETCH addresses 0, 2; pc=3 at halt. Repeat with ac=16'h0005 -> addresses 0, 1.
3. SKIP lt (16'h8000) with ac=16'hFFFF -> skip taken; with ac=16'h7FFF -> not taken. SKIP gt (16'h8800) with ac=16'h8000 -> not taken.
4. mem[0]=16'h9123 (JUMP 0x123), mem[0x123]=HALT -> next mem_addr=12'h123; pc=12'h124 at halt. JUMP 0xFFF then HALT at 0xFFF -> pc wraps to 0.
5. Datapath op 16'h1045, exec_done 3 cycles after exec_start, mem_ack delayed 2 cycles -> exec_start for 1 cycle with exec_op=1, exec_operand=12'h045; retire on the exec_done cycle; mem_req held through the ack delay.
6. rst=0 during WAIT_EXEC with exec_done asserted on that same cycle -> IDLE, pc=RESET_PC, no retire pulse.

Source files
------------

// File: rtl/acc_cpu_sequencer.sv
// Fetch/decode/execute sequencer for the 16-bit accumulator machine; owns PC and IR.
// Define ACC_SEQ_SINGLE_STEP_EN to add the step input and a PAUSE state after every retire.
module acc_cpu_sequencer #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 16,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
`ifdef ACC_SEQ_SINGLE_STEP_EN
  input  logic              step,
`endif
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [DATA_W-1:0] ac,
  output logic              exec_start,
  output logic [3:0]        exec_op,
  output logic [ADDR_W-1:0] exec_operand,
  input  logic              exec_done,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              retire
);

  localparam logic [3:0] OP_HALT = 4'h0;
  localparam logic [3:0] OP_SKIP = 4'h8;
  localparam logic [3:0] OP_JUMP = 4'h9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WAIT_EXEC,
    S_HALTED
`ifdef ACC_SEQ_SINGLE_STEP_EN
    , S_PAUSE
`endif
  } state_t;

`ifdef ACC_SEQ_SINGLE_STEP_EN
  localparam state_t RETIRE_NXT = S_PAUSE;
`else
  localparam state_t RETIRE_NXT = S_FETCH;
`endif

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   pc_q;
  logic [DATA_W-1:0]   ir_q;
  logic [3:0]          opcode;
  logic [1:0]          skip_cond;
  logic                is_ctrl;
  logic                skip_take;
  logic                ac_neg;
  logic                ac_zero;

  assign opcode    = ir_q[DATA_W-1 -: 4];
  assign skip_cond = ir_q[DATA_W-5 -: 2];
  assign is_ctrl   = (opcode == OP_HALT) || (opcode == OP_SKIP) || (opcode == OP_JUMP);
  assign ac_neg    = ac[DATA_W-1];
  assign ac_zero   = (ac == '0);

  always_comb begin
    case (skip_cond)
      2'b00:   skip_take = ac_neg;
      2'b01:   skip_take = ac_zero;
      2'b10:   skip_take = !ac_neg && !ac_zero;
      default: skip_take = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge only.
  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q <= ADDR_W'(RESET_PC);
      ir_q <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (mem_ack) begin
            ir_q <= mem_rdata;
            pc_q <= pc_q + ADDR_W'(1);
          end
        end
        S_DECODE: begin
          if (opcode == OP_JUMP)                  pc_q <= ir_q[ADDR_W-1:0];
          else if (opcode == OP_SKIP && skip_take) pc_q <= pc_q + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    // NOTE: defaulting every comb output first keeps unlisted paths from inferring latches.
    state_nxt = state;
    case (state)
      S_IDLE:      if (run) state_nxt = S_FETCH;
      S_FETCH:     if (mem_ack) state_nxt = S_DECODE;
      S_DECODE: begin
        if (opcode == OP_HALT) state_nxt = S_HALTED;
        else if (is_ctrl)      state_nxt = RETIRE_NXT;
        else                   state_nxt = S_EXEC;
      end
      S_EXEC:      state_nxt = S_WAIT_EXEC;
      S_WAIT_EXEC: if (exec_done) state_nxt = RETIRE_NXT;
      S_HALTED:    if (run) state_nxt = S_FETCH;
`ifdef ACC_SEQ_SINGLE_STEP_EN
      S_PAUSE:     if (step) state_nxt = S_FETCH;
`endif
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Reset is synchronous, so outputs are also masked during the reset cycle itself;
  // a stale exec_done arriving then must not produce a retire pulse.
  always_comb begin
    mem_req    = 1'b0;
    exec_start = 1'b0;
    halted     = 1'b0;
    retire     = 1'b0;
    if (rst) begin
      case (state)
        S_FETCH:     mem_req    = 1'b1;
        S_DECODE:    retire     = is_ctrl;
        S_EXEC:      exec_start = 1'b1;
        S_WAIT_EXEC: retire     = exec_done;
        S_HALTED:    halted     = 1'b1;
        default: ;
      endcase
    end
  end

  assign mem_addr     = pc_q;
  assign pc           = pc_q;
  assign exec_op      = opcode;
  assign exec_operand = ir_q[ADDR_W-1:0];

endmodule

// File: tb/tb_acc_cpu_sequencer.sv
// Self-checking bench for acc_cpu_sequencer: table-driven control-flow programs plus
// hand-written sequences for handshake delays and reset during WAIT_EXEC.
module tb_acc_cpu_sequencer;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              run = 1'b0;
  logic              mem_req, mem_ack, exec_start, exec_done, halted, retire;
  logic [ADDR_W-1:0] mem_addr, exec_operand, pc;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] ac = '0;
  logic [3:0]        exec_op;
`ifdef ACC_SEQ_SINGLE_STEP_EN
  logic              step;
  assign step = 1'b1;
`endif

  logic [DATA_W-1:0] mem [0:4095];
  int   ack_delay = 0;
  int   done_delay = 3;
  int   ack_cnt = 0;
  int   done_cnt = 0;
  logic waiting = 1'b0;
  logic force_done = 1'b0;

  int checks = 0;
  int failures = 0;
  int fetch_cnt = 0;
  int retire_cnt = 0;
  int start_cnt = 0;
  logic [ADDR_W-1:0] fetch_log [0:1023];

  acc_cpu_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(0)) dut (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
`ifdef ACC_SEQ_SINGLE_STEP_EN
    .step         (step),
`endif
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .ac           (ac),
    .exec_start   (exec_start),
    .exec_op      (exec_op),
    .exec_operand (exec_operand),
    .exec_done    (exec_done),
    .pc           (pc),
    .halted       (halted),
    .retire       (retire)
  );

  always #5 clk = ~clk;

  // Memory answers ack_delay cycles after mem_req rises; datapath answers done_delay cycles after exec_start.
  assign mem_rdata = mem[mem_addr];
  assign mem_ack   = mem_req && (ack_cnt == ack_delay);
  assign exec_done = force_done || (waiting && (done_cnt == done_delay));

  always @(posedge clk) begin
    if (mem_req && mem_ack) begin
      fetch_log[fetch_cnt[9:0]] <= mem_addr;
      fetch_cnt <= fetch_cnt + 1;
    end
    if (retire)     retire_cnt <= retire_cnt + 1;
    if (exec_start) start_cnt  <= start_cnt + 1;
    if (mem_req && !mem_ack) ack_cnt <= ack_cnt + 1;
    else                     ack_cnt <= 0;
    if (!rst) waiting <= 1'b0;
    else if (exec_start) begin
      waiting  <= 1'b1;
      done_cnt <= 1;
    end else if (waiting) begin
      if (exec_done) waiting <= 1'b0;
      else           done_cnt <= done_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic load(input logic [15:0] w0, input logic [11:0] a1, input logic [15:0] w1);
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    mem[0]  = w0;
    mem[a1] = w1;
  endtask

  // Leaves the bench at a negedge with rst still low after two reset edges.
  task automatic hold_reset();
    @(negedge clk);
    rst = 1'b0;
    run = 1'b0;
    force_done = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Releases reset, raises run for one edge; returns at the negedge of the first FETCH cycle.
  task automatic start_run();
    rst = 1'b1;
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
  endtask

  task automatic wait_halted(input string name, input int max_cycles);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (halted) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s: halted not seen within %0d cycles", name, max_cycles);
    end
  endtask

  typedef struct {
    string       name;
    logic [15:0] instr;
    logic [15:0] acv;
    logic [11:0] addr2;
    logic [11:0] pc_end;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int bf, br, bs;

    vecs[0] = '{"skip_eq_taken",  16'h8400, 16'h0000, 12'h002, 12'h003};
    vecs[1] = '{"skip_eq_not",    16'h8400, 16'h0005, 12'h001, 12'h002};
    vecs[2] = '{"skip_lt_taken",  16'h8000, 16'hFFFF, 12'h002, 12'h003};
    vecs[3] = '{"skip_lt_not",    16'h8000, 16'h7FFF, 12'h001, 12'h002};
    vecs[4] = '{"skip_lt_zero",   16'h8000, 16'h0000, 12'h001, 12'h002};
    vecs[5] = '{"skip_gt_not",    16'h8800, 16'h8000, 12'h001, 12'h002};
    vecs[6] = '{"skip_gt_taken",  16'h8800, 16'h0001, 12'h002, 12'h003};
    vecs[7] = '{"skip_never",     16'h8C00, 16'h0000, 12'h001, 12'h002};
    vecs[8] = '{"jump_123",       16'h9123, 16'h0000, 12'h123, 12'h124};
    vecs[9] = '{"jump_fff_wrap",  16'h9FFF, 16'h0000, 12'hFFF, 12'h000};

    // Reset state and a lone HALT at address 0.
    load(16'h0000, 12'h000, 16'h0000);
    hold_reset();
    check("rst_pc",         pc, 0);
    check("rst_mem_req",    mem_req, 0);
    check("rst_halted",     halted, 0);
    check("rst_retire",     retire, 0);
    check("rst_exec_start", exec_start, 0);
    bf = fetch_cnt; br = retire_cnt;
    start_run();
    check("halt_fetch_req",  mem_req, 1);
    check("halt_fetch_addr", mem_addr, 0);
    @(negedge clk);
    check("halt_decode_retire", retire, 1);
    check("halt_decode_halted", halted, 0);
    @(negedge clk);
    check("halt_halted",  halted, 1);
    check("halt_pc",      pc, 1);
    check("halt_retires", retire_cnt - br, 1);
    check("halt_fetches", fetch_cnt - bf, 1);

    // Control-flow programs: one instruction at 0, then HALT wherever control lands.
    for (int v = 0; v < 10; v++) begin
      load(vecs[v].instr, 12'h000, vecs[v].instr);
      ac = vecs[v].acv;
      hold_reset();
      bf = fetch_cnt; br = retire_cnt;
      start_run();
      wait_halted(vecs[v].name, 20);
      check({vecs[v].name, "_fetches"}, fetch_cnt - bf, 2);
      check({vecs[v].name, "_addr0"},   fetch_log[bf[9:0]], 0);
      check({vecs[v].name, "_addr1"},   fetch_log[(bf + 1) % 1024], vecs[v].addr2);
      check({vecs[v].name, "_pc"},      pc, vecs[v].pc_end);
      check({vecs[v].name, "_retires"}, retire_cnt - br, 2);
    end
    ac = '0;

    // Datapath op with delayed memory ack and exec_done three cycles after exec_start.
    load(16'h1045, 12'h001, 16'h0000);
    ack_delay = 2;
    done_delay = 3;
    hold_reset();
    bf = fetch_cnt; br = retire_cnt; bs = start_cnt;
    start_run();
    check("dp_f0_req", mem_req, 1);
    check("dp_f0_ack", mem_ack, 0);
    @(negedge clk);
    check("dp_f1_req", mem_req, 1);
    check("dp_f1_ack", mem_ack, 0);
    @(negedge clk);
    check("dp_f2_req", mem_req, 1);
    check("dp_f2_ack", mem_ack, 1);
    @(negedge clk);
    check("dp_decode_start",  exec_start, 0);
    check("dp_decode_retire", retire, 0);
    @(negedge clk);
    check("dp_exec_start",   exec_start, 1);
    check("dp_exec_op",      exec_op, 4'h1);
    check("dp_exec_operand", exec_operand, 12'h045);
    @(negedge clk);
    check("dp_w1_start",  exec_start, 0);
    check("dp_w1_retire", retire, 0);
    @(negedge clk);
    check("dp_w2_retire", retire, 0);
    @(negedge clk);
    check("dp_w3_retire", retire, 1);
    wait_halted("dp_halt", 30);
    check("dp_pc",      pc, 2);
    check("dp_starts",  start_cnt - bs, 1);
    check("dp_retires", retire_cnt - br, 2);
    check("dp_fetches", fetch_cnt - bf, 2);

    // exec_done coincident with exec_start is ignored; reset in WAIT_EXEC beats a live exec_done.
    load(16'h1045, 12'h001, 16'h0000);
    ack_delay = 0;
    done_delay = 1000;
    hold_reset();
    br = retire_cnt;
    start_run();
    @(negedge clk);
    @(negedge clk);
    force_done = 1'b1;
    #1;
    check("coinc_exec_start", exec_start, 1);
    @(negedge clk);
    force_done = 1'b0;
    #1;
    check("coinc_wait_retire", retire, 0);
    @(negedge clk);
    check("coinc_still_waiting", mem_req, 0);
    check("coinc_pc", pc, 1);
    rst = 1'b0;
    force_done = 1'b1;
    #1;
    check("rstx_retire_masked", retire, 0);
    @(negedge clk);
    rst = 1'b1;
    force_done = 1'b0;
    #1;
    check("rstx_pc",      pc, 0);
    check("rstx_mem_req", mem_req, 0);
    check("rstx_halted",  halted, 0);
    check("rstx_retires", retire_cnt - br, 0);
    @(negedge clk);
    check("rstx_idle", mem_req, 0);
    start_run();
    check("rstx_refetch_req",  mem_req, 1);
    check("rstx_refetch_addr", mem_addr, 0);
    rst = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
